// File: rtl/eth_header_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : eth_header_tx                                              |
// | Description : Ethernet II header serialiser (preamble, SFD, MACs,        |
// |               EtherType), one byte per aclk, feeding the IP header stage.|
// |               Define ETH_HEADER_VLAN_EN to insert an 802.1Q tag.         |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module eth_header_tx #(
  parameter int          PREAMBLE_LEN = 7,
  parameter logic [15:0] ETHERTYPE    = 16'h0800,
  parameter logic [15:0] VLAN_TCI     = 16'h0001
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        start,
  input  logic [47:0] mac_d_addr,
  input  logic [47:0] mac_s_addr,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        busy,
  output logic        eth_header_ip_tx_done
);

  localparam logic [2:0] c_pre_last = 3'(PREAMBLE_LEN - 1);
  localparam logic [2:0] c_mac_last = 3'd5;

`ifndef ETH_HEADER_VLAN_EN
  localparam logic [15:0] c_unused_vlan_tci = VLAN_TCI;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DST_MAC,
    ST_SRC_MAC,
`ifdef ETH_HEADER_VLAN_EN
    ST_VLAN_TPID,
    ST_VLAN_TCI,
`endif
    ST_ETHERTYPE
  } state_t;

  state_t      r_state;
  logic [2:0]  r_count;
  logic [47:0] r_mac_d;
  logic [47:0] r_mac_s;

  // The MAC registers are consumed as shift registers: the top byte is always the next to send.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state               <= ST_IDLE;
      r_count               <= 3'd0;
      r_mac_d               <= 48'd0;
      r_mac_s               <= 48'd0;
      data_out              <= 8'h00;
      data_valid            <= 1'b0;
      busy                  <= 1'b0;
      eth_header_ip_tx_done <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mac_d    <= mac_d_addr;
            r_mac_s    <= mac_s_addr;
            data_out   <= 8'h55;
            data_valid <= 1'b1;
            busy       <= 1'b1;
            r_count    <= 3'd0;
            r_state    <= ST_PREAMBLE;
          end
        end

        ST_PREAMBLE: begin
          if (r_count == c_pre_last) begin
            data_out <= 8'hD5;
            r_count  <= 3'd0;
            r_state  <= ST_SFD;
          end else begin
            data_out <= 8'h55;
            r_count  <= r_count + 3'd1;
          end
        end

        ST_SFD: begin
          data_out <= r_mac_d[47:40];
          r_mac_d  <= {r_mac_d[39:0], 8'h00};
          r_count  <= 3'd0;
          r_state  <= ST_DST_MAC;
        end

        ST_DST_MAC: begin
          if (r_count == c_mac_last) begin
            data_out <= r_mac_s[47:40];
            r_mac_s  <= {r_mac_s[39:0], 8'h00};
            r_count  <= 3'd0;
            r_state  <= ST_SRC_MAC;
          end else begin
            data_out <= r_mac_d[47:40];
            r_mac_d  <= {r_mac_d[39:0], 8'h00};
            r_count  <= r_count + 3'd1;
          end
        end

        ST_SRC_MAC: begin
          if (r_count == c_mac_last) begin
            r_count <= 3'd0;
`ifdef ETH_HEADER_VLAN_EN
            data_out <= 8'h81;
            r_state  <= ST_VLAN_TPID;
`else
            data_out <= ETHERTYPE[15:8];
            r_state  <= ST_ETHERTYPE;
`endif
          end else begin
            data_out <= r_mac_s[47:40];
            r_mac_s  <= {r_mac_s[39:0], 8'h00};
            r_count  <= r_count + 3'd1;
          end
        end

`ifdef ETH_HEADER_VLAN_EN
        ST_VLAN_TPID: begin
          if (r_count == 3'd0) begin
            data_out <= 8'h00;
            r_count  <= 3'd1;
          end else begin
            data_out <= VLAN_TCI[15:8];
            r_count  <= 3'd0;
            r_state  <= ST_VLAN_TCI;
          end
        end

        ST_VLAN_TCI: begin
          if (r_count == 3'd0) begin
            data_out <= VLAN_TCI[7:0];
            r_count  <= 3'd1;
          end else begin
            data_out <= ETHERTYPE[15:8];
            r_count  <= 3'd0;
            r_state  <= ST_ETHERTYPE;
          end
        end
`endif

        // Second visit (count=1) is the done cycle; IDLE is only entered after it,
        // so a start seen alongside done is not accepted.
        ST_ETHERTYPE: begin
          if (r_count == 3'd0) begin
            data_out              <= ETHERTYPE[7:0];
            eth_header_ip_tx_done <= 1'b1;
            r_count               <= 3'd1;
          end else begin
            data_out              <= 8'h00;
            data_valid            <= 1'b0;
            busy                  <= 1'b0;
            eth_header_ip_tx_done <= 1'b0;
            r_count               <= 3'd0;
            r_state               <= ST_IDLE;
          end
        end

        default: begin
          data_out              <= 8'h00;
          data_valid            <= 1'b0;
          busy                  <= 1'b0;
          eth_header_ip_tx_done <= 1'b0;
          r_count               <= 3'd0;
          r_state               <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eth_header_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_eth_header_tx                                           |
// | Description : Self-checking bench for eth_header_tx (two parameter sets) |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_eth_header_tx;

  localparam logic [15:0] c_tci = 16'h2064;
`ifdef ETH_HEADER_VLAN_EN
  localparam int c_vlan = 4;
`else
  localparam int c_vlan = 0;
`endif

  logic        aclk    = 1'b0;
  logic        aresetn = 1'b0;
  logic        start   = 1'b0;
  logic [47:0] mac_d   = 48'd0;
  logic [47:0] mac_s   = 48'd0;
  logic [7:0]  dout [2];
  logic        dv   [2];
  logic        bsy  [2];
  logic        dn   [2];

  eth_header_tx #(.VLAN_TCI(c_tci)) u_dut0 (
    .aclk(aclk), .aresetn(aresetn), .start(start),
    .mac_d_addr(mac_d), .mac_s_addr(mac_s),
    .data_out(dout[0]), .data_valid(dv[0]), .busy(bsy[0]),
    .eth_header_ip_tx_done(dn[0])
  );

  eth_header_tx #(.PREAMBLE_LEN(1), .ETHERTYPE(16'h0806), .VLAN_TCI(c_tci)) u_dut1 (
    .aclk(aclk), .aresetn(aresetn), .start(start),
    .mac_d_addr(mac_d), .mac_s_addr(mac_s),
    .data_out(dout[1]), .data_valid(dv[1]), .busy(bsy[1]),
    .eth_header_ip_tx_done(dn[1])
  );

  always #5 aclk = ~aclk;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  bit          chk_en = 1'b0;
  int          pl  [2] = '{7, 1};
  logic [15:0] et  [2] = '{16'h0800, 16'h0806};
  int          pos [2] = '{-1, -1};
  logic [47:0] lmd [2];
  logic [47:0] lms [2];

  function automatic int hdr_len(int p);
    return p + 1 + 12 + c_vlan + 2;
  endfunction

  // Byte i of a header, straight from the frame layout.
  function automatic logic [7:0] hdr_byte(int p, logic [15:0] e, int i,
                                          logic [47:0] md, logic [47:0] ms);
    int          j;
    logic [31:0] tag;
    tag = {16'h8100, c_tci};
    j   = i - p;
    if (j < 0)            return 8'h55;
    if (j == 0)           return 8'hD5;
    if (j <= 6)           return md[8*(6-j) +: 8];
    if (j <= 12)          return ms[8*(12-j) +: 8];
    if (j <= 12 + c_vlan) return tag[8*(12+c_vlan-j) +: 8];
    return (j == 13 + c_vlan) ? e[15:8] : e[7:0];
  endfunction

  function automatic logic [47:0] rnd48();
    return {16'($urandom), $urandom};
  endfunction

  task automatic chk(string name, logic [47:0] act, logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: position within the current header, -1 when idle.
  always @(posedge aclk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (!aresetn) begin
        pos[d] <= -1;
      end else if (pos[d] < 0) begin
        if (start) begin
          pos[d] <= 0;
          lmd[d] <= mac_d;
          lms[d] <= mac_s;
        end
      end else if (pos[d] == hdr_len(pl[d]) - 1) begin
        pos[d] <= -1;
      end else begin
        pos[d] <= pos[d] + 1;
      end
    end
  end

  always @(negedge aclk) begin
    logic [7:0] eb;
    bit         act;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        act = (pos[d] >= 0);
        eb  = act ? hdr_byte(pl[d], et[d], pos[d], lmd[d], lms[d]) : 8'h00;
        chk($sformatf("dut%0d data_out", d), 48'(dout[d]), 48'(eb));
        chk($sformatf("dut%0d data_valid", d), 48'(dv[d]), 48'(act));
        chk($sformatf("dut%0d busy", d), 48'(bsy[d]), 48'(act));
        chk($sformatf("dut%0d done", d), 48'(dn[d]),
            48'(pos[d] == hdr_len(pl[d]) - 1));
      end
    end
  end

  initial begin
    int          n;
    int          done0;
    int          done1;
    int          last_done;
    int          gap;
    bit          done_seen;
    bit          prev_dv;
    logic [47:0] lit;
    logic [7:0]  got  [$];
    logic [7:0]  exp0 [$];

    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    chk_en  = 1'b1;

    // Idle after reset
    repeat (10) @(negedge aclk);
    chk("idle busy", 48'(bsy[0]), 48'd0);
    chk("idle data_out", 48'(dout[0]), 48'd0);

    // Directed frame, MAC inputs scrambled right after acceptance
    mac_d = 48'h010203040506;
    mac_s = 48'hAABBCCDDEEFF;
    start = 1'b1;
    n     = cyc;
    @(negedge aclk);
    start = 1'b0;
    mac_d = '1;
    mac_s = '0;
    done0 = -1;
    done1 = -1;
    for (int i = 0; i < 30; i++) begin
      if (dv[0]) got.push_back(dout[0]);
      if (dn[0]) done0 = cyc - n;
      if (dn[1]) done1 = cyc - n;
      @(negedge aclk);
    end
    repeat (7) exp0.push_back(8'h55);
    exp0.push_back(8'hD5);
    lit = 48'h010203040506;
    for (int k = 0; k < 6; k++) exp0.push_back(lit[47-8*k -: 8]);
    lit = 48'hAABBCCDDEEFF;
    for (int k = 0; k < 6; k++) exp0.push_back(lit[47-8*k -: 8]);
`ifdef ETH_HEADER_VLAN_EN
    exp0.push_back(8'h81); exp0.push_back(8'h00);
    exp0.push_back(8'h20); exp0.push_back(8'h64);
`endif
    exp0.push_back(8'h08);
    exp0.push_back(8'h00);
    chk("directed length", 48'(got.size()), 48'(exp0.size()));
    for (int i = 0; i < exp0.size() && i < got.size(); i++)
      chk($sformatf("directed byte %0d", i), 48'(got[i]), 48'(exp0[i]));
    chk("directed done cycle dut0", 48'(done0), 48'(22 + c_vlan));
    chk("directed done cycle dut1", 48'(done1), 48'(16 + c_vlan));

    // start held high, MACs changing every cycle
    start     = 1'b1;
    last_done = -1;
    gap       = -1;
    prev_dv   = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge aclk);
      if (dv[0] && !prev_dv && last_done >= 0 && gap < 0) gap = cyc - last_done;
      if (dn[0]) last_done = cyc;
      prev_dv = dv[0];
      mac_d   = rnd48();
      mac_s   = rnd48();
    end
    start = 1'b0;
    chk("back-to-back gap", 48'(gap), 48'd2);

    // Reset inside DST_MAC aborts the frame with no done pulse
    repeat (30) @(negedge aclk);
    mac_d = rnd48();
    mac_s = rnd48();
    start = 1'b1;
    n     = cyc;
    @(negedge aclk);
    start = 1'b0;
    while (cyc < n + 10) @(negedge aclk);
    aresetn   = 1'b0;
    done_seen = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    chk("abort data_valid", 48'(dv[0]), 48'd0);
    for (int i = 0; i < 15; i++) begin
      @(negedge aclk);
      if (dn[0] || dn[1]) done_seen = 1'b1;
    end
    chk("abort no done", 48'(done_seen), 48'd0);
    mac_d = rnd48();
    mac_s = rnd48();
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    repeat (30) @(negedge aclk);

    // Random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      start   = ($urandom_range(0, 3) == 0);
      aresetn = ($urandom_range(0, 149) != 0);
      mac_d   = rnd48();
      mac_s   = rnd48();
      @(negedge aclk);
    end
    start   = 1'b0;
    aresetn = 1'b1;
    repeat (30) @(negedge aclk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
